// File: rtl/i2s_unit_if.sv
// Sample-pair request/delivery and I2S pin bundle for i2s_unit.
// slave = the transmitter, master = the sample source and pin observer.
interface i2s_unit_if #(
  parameter int DATA_W = 24
);
  logic              play_in;
  logic              tick_in;
  logic [DATA_W-1:0] audio0_in;
  logic [DATA_W-1:0] audio1_in;
  logic              req_out;
  logic              sck_out;
  logic              ws_out;
  logic              sdo_out;

  modport master (
    output play_in, tick_in, audio0_in, audio1_in,
    input  req_out, sck_out, ws_out, sdo_out
  );

  modport slave (
    input  play_in, tick_in, audio0_in, audio1_in,
    output req_out, sck_out, ws_out, sdo_out
  );
endinterface

// File: rtl/i2s_unit.sv
// Philips I2S transmitter: one-pair holding buffer, STOP/PLAY/DRAIN control, 1-cycle registered pins.
// Build option I2S_UNDERRUN_REPEAT_EN: an underrun replays the last loaded pair instead of silence.
module i2s_unit #(
  parameter int MCLK_DIV = 8,
  parameter int DATA_W   = 24
) (
  input logic       mclk,
  input logic       rst,
  i2s_unit_if.slave bus
);
  localparam int FW = 2 * DATA_W;
  localparam int DW = (MCLK_DIV > 2) ? $clog2(MCLK_DIV) : 1;
  localparam int BW = $clog2(FW);
  localparam logic [DW-1:0] D_LAST = DW'(MCLK_DIV - 1);
  localparam logic [DW-1:0] D_HALF = DW'(MCLK_DIV / 2);
  localparam logic [BW-1:0] B_LAST = BW'(FW - 1);
  localparam logic [BW-1:0] WS_LO  = BW'(DATA_W - 1);
  localparam logic [BW-1:0] WS_HI  = BW'(FW - 2);

  typedef enum logic [1:0] {
    STOP  = 2'd0,
    PLAY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [DW-1:0] d;
  logic [BW-1:0] b;
  logic [FW-1:0] sr;
  logic [FW-1:0] hold;
  logic          full;
  logic          sck_q, ws_q, sdo_q, req_q;

  logic [FW-1:0] tick_dat;
  logic [FW-1:0] under_dat;
  logic [FW-1:0] load_dat;
  logic          d_wrap;
  logic          frame_end;
  logic          load;
  logic          out_en;

  assign tick_dat  = {bus.audio0_in, bus.audio1_in};
  assign d_wrap    = (d == D_LAST);
  assign frame_end = d_wrap && (b == B_LAST);
  assign load      = ((state == STOP) && bus.play_in) || ((state == PLAY) && frame_end);
  // The DRAIN end-of-frame cycle already blanks the pins so they read 0 as STOP begins.
  assign out_en    = (state == PLAY) || ((state == DRAIN) && !frame_end);

`ifdef I2S_UNDERRUN_REPEAT_EN
  logic [FW-1:0] last_q;

  always_ff @(posedge mclk) begin
    if (rst) begin
      last_q <= '0;
    end else if (load) begin
      last_q <= load_dat;
    end else if (state == STOP) begin
      last_q <= '0;
    end
  end

  assign under_dat = last_q;
`else
  assign under_dat = '0;
`endif

  always_comb begin
    load_dat = under_dat;
    if (full) begin
      load_dat = hold;
    end else if (bus.tick_in) begin
      load_dat = tick_dat;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      STOP:    if (bus.play_in) state_nx = PLAY;
      PLAY:    if (!bus.play_in) state_nx = DRAIN;
      DRAIN:   if (frame_end) state_nx = STOP;
      default: state_nx = STOP;
    endcase
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      state <= STOP;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      d     <= '0;
      b     <= '0;
      sr    <= '0;
      hold  <= '0;
      full  <= 1'b0;
      sck_q <= 1'b0;
      ws_q  <= 1'b0;
      sdo_q <= 1'b0;
      req_q <= 1'b0;
    end else begin
      if (state == STOP) begin
        d <= '0;
        b <= '0;
      end else begin
        d <= d_wrap ? '0 : d + DW'(1);
        if (d_wrap) begin
          b <= (b == B_LAST) ? '0 : b + BW'(1);
        end
      end

      if (load) begin
        sr <= load_dat;
      end else if (state == STOP) begin
        sr <= '0;
      end else if (d_wrap) begin
        sr <= {sr[FW-2:0], 1'b0};
      end

      // A tick coinciding with a full-buffer load refills the buffer behind the outgoing pair.
      if (state == STOP) begin
        hold <= '0;
        full <= 1'b0;
      end else if (load) begin
        if (full && bus.tick_in) begin
          hold <= tick_dat;
        end else begin
          full <= 1'b0;
        end
      end else if (bus.tick_in) begin
        hold <= tick_dat;
        full <= 1'b1;
      end

      req_q <= load && bus.play_in;

      if (out_en) begin
        sck_q <= (d >= D_HALF);
        ws_q  <= (b >= WS_LO) && (b <= WS_HI);
        sdo_q <= sr[FW-1];
      end else begin
        sck_q <= 1'b0;
        ws_q  <= 1'b0;
        sdo_q <= 1'b0;
      end
    end
  end

  assign bus.req_out = req_q;
  assign bus.sck_out = sck_q;
  assign bus.ws_out  = ws_q;
  assign bus.sdo_out = sdo_q;
endmodule
